// File: rtl/secuenciador_temporizador.sv
// Phase scheduler for the M:SS BCD countdown timer: latches a program of
// N_FASES durations, loads each valid one in turn and flags the active phase.
module secuenciador_temporizador #(
  parameter int N_FASES = 4,
  parameter int IDX_W   = 2
) (
  input  logic                   clk_1h,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pausa,
  input  logic                   abortar,
  input  logic [12*N_FASES-1:0]  prog_tiempos,
  input  logic                   tmr_cero,
  output logic                   tmr_carga,
  output logic [11:0]            tmr_tiempo,
  output logic                   tmr_pausa,
  output logic [IDX_W-1:0]       fase,
  output logic [N_FASES-1:0]     salida_fase,
  output logic                   fin,
  output logic                   error_cfg
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCAN  = 3'd1,
    S_CARGA = 3'd2,
    S_RUN   = 3'd3,
    S_PAUSA = 3'd4,
    S_FIN   = 3'd5
  } estado_t;

  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_FASES - 1);
  localparam logic [N_FASES-1:0] ONE_HOT0 = N_FASES'(1);

  estado_t                   state_r, state_n_s;
  logic [IDX_W-1:0]          idx_r, idx_n_s;
  logic [N_FASES-1:0][11:0]  prog_r;
  logic [11:0]               fase_val_s;
  logic                      latch_s, err_set_s;
  logic                      carga_n_s, pausa_n_s, fin_n_s, err_n_s;
  logic [11:0]               tiempo_n_s;
  logic [IDX_W-1:0]          fase_n_s;
  logic [N_FASES-1:0]        salida_n_s;

  function automatic logic bcd_ok(input logic [11:0] t);
    return (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  assign fase_val_s = prog_r[idx_r];

  // State, phase index and latched program registers
  always_ff @(posedge clk_1h or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
      prog_r  <= '0;
    end else begin
      state_r <= state_n_s;
      idx_r   <= idx_n_s;
      if (latch_s) begin
        prog_r <= prog_tiempos;
      end
    end
  end

  // Next-state logic; abortar dominates, then tmr_cero, then pausa, then start
  always_comb begin
    state_n_s = state_r;
    idx_n_s   = idx_r;
    latch_s   = 1'b0;
    err_set_s = 1'b0;
    if (abortar) begin
      state_n_s = S_IDLE;
      idx_n_s   = '0;
    end else begin
      case (state_r)
        S_IDLE, S_FIN: begin
          if (start) begin
            state_n_s = S_SCAN;
            idx_n_s   = '0;
            latch_s   = 1'b1;
          end else begin
            state_n_s = state_r;
          end
        end
        S_SCAN: begin
          if (!bcd_ok(fase_val_s) || (fase_val_s == 12'h000)) begin
            err_set_s = !bcd_ok(fase_val_s);
            if (idx_r == IDX_LAST) begin
              state_n_s = S_FIN;
            end else begin
              idx_n_s = idx_r + IDX_W'(1);
            end
          end else begin
            state_n_s = S_CARGA;
          end
        end
        S_CARGA: state_n_s = S_RUN;
        S_RUN: begin
          if (tmr_cero) begin
            if (idx_r == IDX_LAST) begin
              state_n_s = S_FIN;
            end else begin
              state_n_s = S_SCAN;
              idx_n_s   = idx_r + IDX_W'(1);
            end
          end else if (pausa) begin
            state_n_s = S_PAUSA;
          end else begin
            state_n_s = S_RUN;
          end
        end
        S_PAUSA: begin
          if (pausa) begin
            state_n_s = S_RUN;
          end else begin
            state_n_s = S_PAUSA;
          end
        end
        default: state_n_s = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state so the registered outputs track the state
  always_comb begin
    carga_n_s  = (state_n_s == S_CARGA);
    pausa_n_s  = (state_n_s != S_RUN);
    fin_n_s    = (state_n_s == S_FIN);
    tiempo_n_s = tmr_tiempo;
    fase_n_s   = fase;
    if (abortar) begin
      tiempo_n_s = 12'h000;
      fase_n_s   = '0;
    end else if (state_n_s == S_CARGA) begin
      tiempo_n_s = fase_val_s;
      fase_n_s   = idx_r;
    end else begin
      tiempo_n_s = tmr_tiempo;
    end
    if ((state_n_s == S_RUN) || (state_n_s == S_PAUSA)) begin
      salida_n_s = ONE_HOT0 << idx_n_s;
    end else begin
      salida_n_s = '0;
    end
    if (latch_s) begin
      err_n_s = 1'b0;
    end else if (err_set_s) begin
      err_n_s = 1'b1;
    end else begin
      err_n_s = error_cfg;
    end
  end

  // Registered outputs
  always_ff @(posedge clk_1h or negedge reset) begin
    if (!reset) begin
      tmr_carga   <= 1'b0;
      tmr_tiempo  <= 12'h000;
      tmr_pausa   <= 1'b1;
      fase        <= '0;
      salida_fase <= '0;
      fin         <= 1'b0;
      error_cfg   <= 1'b0;
    end else begin
      tmr_carga   <= carga_n_s;
      tmr_tiempo  <= tiempo_n_s;
      tmr_pausa   <= pausa_n_s;
      fase        <= fase_n_s;
      salida_fase <= salida_n_s;
      fin         <= fin_n_s;
      error_cfg   <= err_n_s;
    end
  end

endmodule

// File: tb/tb_secuenciador_temporizador.sv
// Bench for secuenciador_temporizador: a seconds-count timer model drives
// tmr_cero, and a program-level model predicts loads, phases and FIN timing.
module tb_secuenciador_temporizador;
  localparam int NF = 4;
  localparam int IW = 2;

  logic              clk_1h = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0, pausa = 1'b0, abortar = 1'b0;
  logic [12*NF-1:0]  prog_tiempos = '0;
  logic              tmr_cero;
  logic              tmr_carga, tmr_pausa, fin, error_cfg;
  logic [11:0]       tmr_tiempo;
  logic [IW-1:0]     fase;
  logic [NF-1:0]     salida_fase;

  int n_assert = 0;
  int n_fail = 0;
  int cnt = 0;
  int exp_fase = 0;

  logic [11:0] exp_loads[$], obs_loads[$];
  int          exp_idx[$], obs_idx[$], obs_sal[$];
  int          exp_err, exp_T, exp_first, exp_pcyc;
  int          obs_T, obs_first, obs_pcyc, last_zero, onehot_err;

  always #5 clk_1h = ~clk_1h;

  secuenciador_temporizador #(.N_FASES(NF), .IDX_W(IW)) dut (
    .clk_1h(clk_1h), .reset(rst_n), .start(start), .pausa(pausa),
    .abortar(abortar), .prog_tiempos(prog_tiempos), .tmr_cero(tmr_cero),
    .tmr_carga(tmr_carga), .tmr_tiempo(tmr_tiempo), .tmr_pausa(tmr_pausa),
    .fase(fase), .salida_fase(salida_fase), .fin(fin), .error_cfg(error_cfg)
  );

  function automatic int secs(input logic [11:0] t);
    return int'(t[11:8]) * 60 + int'(t[7:4]) * 10 + int'(t[3:0]);
  endfunction

  // Timer model: counts whole seconds, loads on tmr_carga, holds on tmr_pausa
  always @(posedge clk_1h or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (tmr_carga) cnt <= secs(tmr_tiempo);
    else if (!tmr_pausa && cnt > 0) cnt <= cnt - 1;
  end
  assign tmr_cero = (cnt == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Program-level model: skip/invalid phases cost one cycle, a loaded phase
  // costs SCAN + CARGA + (duration+1) RUN cycles, plus any pause length.
  task automatic model(input logic [12*NF-1:0] p, input int pa, input int plen);
    int t;
    bit paused;
    logic [11:0] v;
    exp_loads.delete(); exp_idx.delete();
    exp_err = 0; exp_first = -1; exp_pcyc = 0; t = 0; paused = 0;
    for (int k = 0; k < NF; k++) begin
      v = p[12*k +: 12];
      if (v[11:8] > 4'd9 || v[7:4] > 4'd5 || v[3:0] > 4'd9) begin
        exp_err = 1; t += 1;
      end else if (secs(v) == 0) begin
        t += 1;
      end else begin
        if (exp_first < 0) exp_first = t + 2;
        exp_loads.push_back(v);
        exp_idx.push_back(k);
        t += 3 + secs(v);
        if (!paused && pa > 0 && secs(v) >= pa) begin
          paused = 1; t += plen; exp_pcyc = plen;
        end
      end
    end
    exp_T = t;
  endtask

  task automatic run_prog(input logic [12*NF-1:0] p, input int pa, input int plen);
    int cyc, pst, pc, n;
    logic [NF-1:0] last_sal;
    obs_loads.delete(); obs_idx.delete(); obs_sal.delete();
    obs_first = -1; obs_pcyc = 0; last_zero = -1; onehot_err = 0;
    last_sal = '0; pst = 0; pc = 0; cyc = 0;
    prog_tiempos = p;
    start = 1'b1;
    @(negedge clk_1h);
    start = 1'b0;
    prog_tiempos = {$urandom, $urandom};
    while (fin !== 1'b1 && cyc < 400) begin
      if (tmr_carga) begin
        obs_loads.push_back(tmr_tiempo);
        obs_idx.push_back(int'(fase));
        if (obs_first < 0) obs_first = cyc + 1;
      end
      if (salida_fase != last_sal && salida_fase != '0) obs_sal.push_back(int'(salida_fase));
      last_sal = salida_fase;
      if ($countones(salida_fase) > 1) onehot_err++;
      if (tmr_pausa && salida_fase != '0) obs_pcyc++;
      if (tmr_cero && !tmr_pausa && salida_fase != '0) last_zero = cyc;
      if (pst == 0 && pa > 0 && salida_fase != '0 && !tmr_pausa && cnt == pa) begin
        pausa = 1'b1; pst = 1;
      end else if (pst == 1) begin
        pc++;
        if (pc == plen) begin pausa = 1'b1; pst = 2; end
        else pausa = 1'b0;
      end else begin
        pausa = 1'b0;
      end
      @(negedge clk_1h);
      cyc++;
    end
    pausa = 1'b0;
    obs_T = cyc;
    model(p, pa, plen);
    chk("fin_cycles", obs_T, exp_T);
    chk("n_loads", obs_loads.size(), exp_loads.size());
    chk("n_salida", obs_sal.size(), exp_loads.size());
    n = (obs_loads.size() < exp_loads.size()) ? obs_loads.size() : exp_loads.size();
    for (int i = 0; i < n; i++) begin
      chk("load_val", obs_loads[i], exp_loads[i]);
      chk("load_fase", obs_idx[i], exp_idx[i]);
      if (i < obs_sal.size()) chk("salida_seq", obs_sal[i], 32'd1 << exp_idx[i]);
    end
    chk("first_carga", obs_first, exp_first);
    chk("error_cfg", error_cfg, exp_err);
    chk("pause_cycles", obs_pcyc, exp_pcyc);
    chk("onehot", onehot_err, 0);
    if (exp_loads.size() > 0) exp_fase = exp_idx[exp_idx.size()-1];
    if (exp_loads.size() > 0 && exp_fase == NF - 1) chk("fin_after_zero", obs_T - last_zero, 1);
    chk("fase_end", fase, exp_fase);
    chk("fin", fin, 1);
    chk("salida_fin", salida_fase, 0);
    chk("pausa_fin", tmr_pausa, 1);
  endtask

  task automatic abort_at(input logic [NF-1:0] target, input bit at_zero);
    int k, nc;
    logic err_before;
    k = 0;
    while (!(salida_fase == target && !tmr_pausa && (at_zero ? (cnt == 0) : (cnt == 2))) && k < 300) begin
      @(negedge clk_1h);
      k++;
    end
    chk("abort_reach", k < 300, 1);
    err_before = error_cfg;
    abortar = 1'b1;
    @(negedge clk_1h);
    abortar = 1'b0;
    exp_fase = 0;
    chk("abort_salida", salida_fase, 0);
    chk("abort_pausa", tmr_pausa, 1);
    chk("abort_fin", fin, 0);
    chk("abort_carga", tmr_carga, 0);
    chk("abort_fase", fase, 0);
    chk("abort_tiempo", tmr_tiempo, 0);
    chk("abort_err", error_cfg, err_before);
    nc = 0;
    repeat (12) begin
      @(negedge clk_1h);
      if (tmr_carga) nc++;
    end
    chk("abort_no_carga", nc, 0);
    chk("abort_idle_salida", salida_fase, 0);
  endtask

  function automatic logic [11:0] rnd_phase();
    case ($urandom % 4)
      0: return 12'h000;
      1: case ($urandom % 3)
           0: return {4'(10 + $urandom % 6), 4'd0, 4'd1};
           1: return {4'd0, 4'(6 + $urandom % 10), 4'd2};
           default: return {4'd0, 4'd0, 4'(10 + $urandom % 6)};
         endcase
      default: return {4'd0, 4'($urandom % 2), 4'($urandom % 10)};
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_carga"}, tmr_carga, 0);
    chk({tag, "_tiempo"}, tmr_tiempo, 0);
    chk({tag, "_pausa"}, tmr_pausa, 1);
    chk({tag, "_fase"}, fase, 0);
    chk({tag, "_salida"}, salida_fase, 0);
    chk({tag, "_fin"}, fin, 0);
    chk({tag, "_err"}, error_cfg, 0);
  endtask

  initial begin
    logic [12*NF-1:0] rp;
    int k;
    repeat (2) @(negedge clk_1h);
    check_reset_vals("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk_1h);

    run_prog({12'h002, 12'h000, 12'h003, 12'h005}, 0, 0);
    run_prog({12'h000, 12'h000, 12'h000, 12'h010}, 7, 5);
    run_prog({12'h002, 12'h003, 12'h0A5, 12'h005}, 0, 0);
    run_prog({12'h001, 12'h001, 12'h001, 12'h001}, 0, 0);
    run_prog({12'h000, 12'h000, 12'h000, 12'h000}, 0, 0);

    prog_tiempos = {12'h002, 12'h004, 12'h003, 12'h002};
    start = 1'b1; @(negedge clk_1h); start = 1'b0;
    abort_at(4'b0100, 1'b0);
    start = 1'b1; @(negedge clk_1h); start = 1'b0;
    abort_at(4'b0100, 1'b1);

    prog_tiempos = {12'h000, 12'h000, 12'h000, 12'h009};
    start = 1'b1; @(negedge clk_1h); start = 1'b0;
    k = 0;
    while (salida_fase != 4'b0001 && k < 50) begin @(negedge clk_1h); k++; end
    chk("rst_reach_run", k < 50, 1);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("async_rst");
    @(negedge clk_1h);
    rst_n = 1'b1;
    exp_fase = 0;
    @(negedge clk_1h);
    run_prog({12'h000, 12'h004, 12'h000, 12'h002}, 0, 0);

    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < NF; j++) rp[12*j +: 12] = rnd_phase();
      run_prog(rp, 1 + int'($urandom % 3), 1 + int'($urandom % 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
